// File: rtl/idct1d_pipe_if.sv
// Valid/ready stream carrying one 8-element vector of signed Q8 values.
//   valid  : producer has a vector on data this cycle
//   ready  : consumer accepts the vector this cycle
//   data   : eight W-bit lanes, lane i = element i
// master drives valid/data, slave drives ready.
interface idct1d_pipe_if #(
  parameter int unsigned W = 22
);
  logic                valid;
  logic                ready;
  logic [7:0][W-1:0]   data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/idct1d_pipe.sv
// 8-point 1-D inverse DCT (AAN flow graph), 6 register stages, global-stall
// valid/ready pipeline. Inputs are AAN-prescaled signed Q8 coefficients.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   in_if   : slave stream, data[i] = X<i> (natural frequency order),
//             ready is combinational (= pipeline enable)
//   out_if  : master stream, data[i] = x<i> spatial samples, registered
module idct1d_pipe #(
  parameter int unsigned W     = 22,
  parameter logic [29:0] C1414 = 30'h16A,
  parameter logic [29:0] C1848 = 30'h1D9,
  parameter logic [29:0] C1082 = 30'h115,
  parameter logic [29:0] C2613 = 30'h29D
) (
  input  logic           clk,
  input  logic           reset,
  idct1d_pipe_if.slave   in_if,
  idct1d_pipe_if.master  out_if
);

  localparam int unsigned MW   = 30;
  localparam int unsigned FRAC = 8;

  // Q8 constant multiply: sign-extend to MW, multiply, floor-shift, keep W bits.
  function automatic logic [W-1:0] mulc(input logic [W-1:0] a, input logic [MW-1:0] c);
    logic signed [MW-1:0] p;
    p = MW'($signed(a)) * $signed(c);
    return W'(p >>> FRAC);
  endfunction

  logic             en;
  logic [7:0][W-1:0] xin;
  logic [7:0][W-1:0] out_q;
  logic             v1, v2, v3, v4, v5, v6;

  // stage 1: input butterflies
  logic [W-1:0] a_t10, a_t11, a_t13, a_d26, a_z13, a_z10, a_z11, a_z12;
  // stage 2: even multiply, odd sums
  logic [W-1:0] b_t10, b_t11, b_t13, b_m26, b_o7, b_d, b_s, b_z10, b_z12;
  // stage 3: even e0/e3, odd multiplies
  logic [W-1:0] c_e0, c_e3, c_t11, c_t12, c_o7, c_u11, c_z5, c_mz12, c_mz10;
  // stage 4: all even terms, u10/u12
  logic [W-1:0] d_e0, d_e1, d_e2, d_e3, d_o7, d_u11, d_u10, d_u12;
  // stage 5: o6
  logic [W-1:0] e_e0, e_e1, e_e2, e_e3, e_o7, e_o6, e_u11, e_u10;
  logic [W-1:0] o5_c, o4_c;

  assign xin          = in_if.data;
  assign en           = !v6 | out_if.ready;
  assign in_if.ready  = en;
  assign out_if.valid = v6;
  assign out_if.data  = out_q;

  // Tail of the odd chain feeds the output butterflies directly.
  always_comb begin
    o5_c = e_u11 - e_o6;
    o4_c = e_u10 - o5_c;
  end

  // Whole pipeline advances only when en; a bubble travels as a valid=0 slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {v1, v2, v3, v4, v5, v6} <= '0;
      {a_t10, a_t11, a_t13, a_d26, a_z13, a_z10, a_z11, a_z12} <= '0;
      {b_t10, b_t11, b_t13, b_m26, b_o7, b_d, b_s, b_z10, b_z12} <= '0;
      {c_e0, c_e3, c_t11, c_t12, c_o7, c_u11, c_z5, c_mz12, c_mz10} <= '0;
      {d_e0, d_e1, d_e2, d_e3, d_o7, d_u11, d_u10, d_u12} <= '0;
      {e_e0, e_e1, e_e2, e_e3, e_o7, e_o6, e_u11, e_u10} <= '0;
      out_q <= '0;
    end else if (en) begin
      v1 <= in_if.valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      v5 <= v4;
      v6 <= v5;

      a_t10 <= xin[0] + xin[4];
      a_t11 <= xin[0] - xin[4];
      a_t13 <= xin[2] + xin[6];
      a_d26 <= xin[2] - xin[6];
      a_z13 <= xin[5] + xin[3];
      a_z10 <= xin[5] - xin[3];
      a_z11 <= xin[1] + xin[7];
      a_z12 <= xin[1] - xin[7];

      b_t10 <= a_t10;
      b_t11 <= a_t11;
      b_t13 <= a_t13;
      b_m26 <= mulc(a_d26, C1414);
      b_o7  <= a_z11 + a_z13;
      b_d   <= a_z11 - a_z13;
      b_s   <= a_z10 + a_z12;
      b_z10 <= a_z10;
      b_z12 <= a_z12;

      c_e0   <= b_t10 + b_t13;
      c_e3   <= b_t10 - b_t13;
      c_t11  <= b_t11;
      c_t12  <= b_m26 - b_t13;
      c_o7   <= b_o7;
      c_u11  <= mulc(b_d, C1414);
      c_z5   <= mulc(b_s, C1848);
      c_mz12 <= mulc(b_z12, C1082);
      c_mz10 <= mulc(b_z10, C2613);

      d_e0  <= c_e0;
      d_e3  <= c_e3;
      d_e1  <= c_t11 + c_t12;
      d_e2  <= c_t11 - c_t12;
      d_o7  <= c_o7;
      d_u11 <= c_u11;
      d_u10 <= c_z5 - c_mz12;
      d_u12 <= c_z5 - c_mz10;

      e_e0  <= d_e0;
      e_e1  <= d_e1;
      e_e2  <= d_e2;
      e_e3  <= d_e3;
      e_o7  <= d_o7;
      e_o6  <= d_u12 - d_o7;
      e_u11 <= d_u11;
      e_u10 <= d_u10;

      out_q[0] <= e_e0 + e_o7;
      out_q[7] <= e_e0 - e_o7;
      out_q[1] <= e_e1 + e_o6;
      out_q[6] <= e_e1 - e_o6;
      out_q[2] <= e_e2 + o5_c;
      out_q[5] <= e_e2 - o5_c;
      out_q[3] <= e_e3 + o4_c;
      out_q[4] <= e_e3 - o4_c;
    end
  end

endmodule
